// File: rtl/axis_block_arbiter_pkg.sv
// Shared types for the block round-robin AXIS arbiter.
// AXIS_BLOCK_ARBITER_LAST_EN adds a last-of-block tag bit.
package axis_block_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic id;
    logic first;
`ifdef AXIS_BLOCK_ARBITER_LAST_EN
    logic last;
`endif
  } beat_tag_t;

  localparam int TAG_W = $bits(beat_tag_t);

endpackage

// File: rtl/axis_register_slice.sv
// One-entry valid/ready register slice with a generic payload.
// Accepts a new beat in the same cycle the held one drains.
module axis_register_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             load;

  always_comb begin
    in_ready = !valid_q || out_ready;
    load     = in_valid && in_ready;
    valid_d  = load || (valid_q && !out_ready);
    data_d   = load ? in_data : data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/axis_block_arbiter.sv
// Two-input round-robin AXIS arbiter granting whole blocks.
// Optional output_last port under AXIS_BLOCK_ARBITER_LAST_EN.
module axis_block_arbiter
  import axis_block_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int BLOCK_SIZE_LOG = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  input_0_valid,
  output logic                  input_0_ready,
  input  logic [DATA_WIDTH-1:0] input_0_data,
  input  logic                  input_1_valid,
  output logic                  input_1_ready,
  input  logic [DATA_WIDTH-1:0] input_1_data,
  output logic                  output_valid,
  input  logic                  output_ready,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_id,
  output logic                  output_first
`ifdef AXIS_BLOCK_ARBITER_LAST_EN
  ,
  output logic                  output_last
`endif
);

  localparam int CW = (BLOCK_SIZE_LOG > 0) ? BLOCK_SIZE_LOG : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'((1 << BLOCK_SIZE_LOG) - 1);
  localparam int PW = TAG_W + DATA_WIDTH;

  state_e          state_q;
  state_e          state_d;
  logic            grant_q;
  logic            grant_d;
  logic            last_grant_q;
  logic            last_grant_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            slice_ready;
  logic            hs;
  beat_tag_t       in_tag;
  beat_tag_t       out_tag;
  logic [PW-1:0]   in_payload;
  logic [PW-1:0]   out_payload;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    cnt_d         = cnt_q;
    input_0_ready = 1'b0;
    input_1_ready = 1'b0;
    hs            = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (input_0_valid || input_1_valid) begin
          state_d = GRANT;
          cnt_d   = '0;
          // Tie goes to whoever did not own the previous block.
          grant_d = (input_0_valid && input_1_valid) ?
                    !last_grant_q : input_1_valid;
        end
      end
      GRANT: begin
        input_0_ready = !grant_q && slice_ready;
        input_1_ready = grant_q && slice_ready;
        hs = grant_q ? (input_1_valid && input_1_ready)
                     : (input_0_valid && input_0_ready);
        if (hs) begin
          if (cnt_q == CNT_MAX) begin
            cnt_d        = '0;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_tag       = '0;
    in_tag.id    = grant_q;
    in_tag.first = (cnt_q == '0);
`ifdef AXIS_BLOCK_ARBITER_LAST_EN
    in_tag.last  = (cnt_q == CNT_MAX);
`endif
    in_payload   = {in_tag, grant_q ? input_1_data : input_0_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  axis_register_slice #(
    .WIDTH(PW)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .in_valid (hs),
    .in_ready (slice_ready),
    .in_data  (in_payload),
    .out_valid(output_valid),
    .out_ready(output_ready),
    .out_data (out_payload)
  );

  assign {out_tag, output_data} = out_payload;
  assign output_id    = out_tag.id;
  assign output_first = out_tag.first;
`ifdef AXIS_BLOCK_ARBITER_LAST_EN
  assign output_last  = out_tag.last;
`endif

endmodule

// File: doc/axis_block_arbiter.md
# axis_block_arbiter

Two-input round-robin AXIS arbiter that shares one downstream 1-in/1-out processing element (accumulator, averager, repeater, clamper, reducer, substituter) between two producers. It grants an input for exactly one block of 2^BLOCK_SIZE_LOG transactions, so blocks from different sources never interleave inside a block-oriented element. The merged stream passes through a one-entry output register, tagged with source id and a first-of-block flag.

## Interface
- DATA_WIDTH, 16, data width of both inputs and the output
- BLOCK_SIZE_LOG, 8, log2 of transactions per grant (block)
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- input_0_valid / input_0_ready / input_0_data  in/out/in  1/1/DATA_WIDTH  requester 0 AXIS slave
- input_1_valid / input_1_ready / input_1_data  in/out/in  1/1/DATA_WIDTH  requester 1 AXIS slave
- output_valid  out  1  registered output valid
- output_ready  in  1  downstream ready
- output_data  out  DATA_WIDTH  registered data of granted input
- output_id  out  1  source index of the current output beat
- output_first  out  1  high on the first beat of each block

## Operation
- FSM states: IDLE, GRANT. Registers: grant (1b), last_grant (1b), beat counter (BLOCK_SIZE_LOG bits), output register (valid, data, id, first).
- IDLE: both input_*_ready = 0. If exactly one input_*_valid is high, grant it; if both, grant !last_grant. Go to GRANT, load grant, clear counter. No valid: stay.
- GRANT: ready of granted input = !output_valid || output_ready; non-granted ready = 0. On input handshake: load output register (data, id = grant, first = (counter == 0)), counter += 1.
- Handshake with counter == 2^BLOCK_SIZE_LOG-1: counter wraps to 0, last_grant <= grant, next state IDLE.
- Output register: output_valid set on load; cleared when output_ready && output_valid and no new load same cycle. Simultaneous drain and load keeps valid high with new contents.
- A granted input that drops valid mid-block stalls the block; the grant is never revoked before the block completes, even if the other input is waiting.
- BLOCK_SIZE_LOG = 0: every block is 1 beat, output_first always 1.

## Timing
- Reset values: state IDLE, last_grant = 1 (input 0 wins first tie), counter 0, output_valid 0, output_data 0, output_id 0, output_first 0, both input readies 0.
- Reset mid-block aborts: the in-flight output beat is discarded, no partial block resumes.
- Input handshake to output_valid: 1 cycle.
- Arbitration bubble: one IDLE cycle per block; with a continuously ready sink a block takes 2^BLOCK_SIZE_LOG + 1 cycles.
- Inside a block with output_ready held high: one beat per cycle, no bubbles.
- input_*_ready is combinational from output_ready and registered state only; it never depends on input_*_valid.

## Configuration
- AXIS_BLOCK_ARBITER_LAST_EN defined: adds port output_last (out, 1), registered with the data, high on the beat loaded when counter == 2^BLOCK_SIZE_LOG-1; reset value 0.
- Undefined: no output_last port or logic; all other behaviour identical.

## Structure
- Shared package: state enum (IDLE, GRANT) and a beat-tag struct (id, first, optional last).
- One sub-module: axis_register_slice (one-entry output register with valid/ready and parameterized payload width), reusable elsewhere in the pipeline.

## Test plan
- BLOCK_SIZE_LOG=2, only input 0 active with data 0,1,2,…, sink always ready -> blocks of 4 beats with id=0, first on 0,4,8, one bubble cycle between blocks.
- Both inputs continuously valid (input 0: 0x000n, input 1: 0x100n) -> output alternates 4 beats id 0, 4 beats id 1, …; first beat 0x0000 then 0x1000.
- Input 0 drops valid after 2 beats while input 1 is valid -> output stalls, no id 1 beat until input 0 delivers beats 3 and 4.
- Sink ready toggling 1010… -> no beat lost or duplicated, data sequence and id intact, output held stable while valid && !ready.
- rst asserted after 2 beats of a block, then both inputs valid -> output_valid 0 next cycle, new block granted to input 0 with first=1.
- With AXIS_BLOCK_ARBITER_LAST_EN, BLOCK_SIZE_LOG=2 -> output_last on beats 3, 7, 11; without it, the port is absent and the bench compiles without it.
